// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the unified memory arbiter
package riscv_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises fetch and load/store accesses onto one single-port memory
module unified_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_LATENCY = 1,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);
   localparam int BE_W = DATA_W / 8;
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
   arb_state_t state, state_n;
   owner_t owner;
   logic [STK_W-1:0] streak;
   logic [CNT_W-1:0] cnt;
   logic we, err, grant_d, grant_i, mis;
   logic [BE_W-1:0] be;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata;

   always_comb begin
      grant_d = d_req && (!if_req || streak < STK_W'(MAX_DATA_STREAK));
      grant_i = !grant_d && if_req;
      mis = |(d_addr[1:0] & ALIGN_MASK);
      state_n = state;
      case (state)
         IDLE:    state_n = grant_d ? (mis ? RESP : ISSUE) : (grant_i ? ISSUE : IDLE);
         ISSUE:   state_n = we ? RESP : WAIT;
         WAIT:    state_n = (cnt == CNT_W'(MEM_LATENCY - 1)) ? RESP : WAIT;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         owner <= OWN_IF;
         streak <= '0;
         cnt <= '0;
         we <= 1'b0;
         err <= 1'b0;
         be <= '0;
         addr <= '0;
         wdata <= '0;
         rdata <= '0;
      end else begin
         state <= state_n;
         cnt <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
         if (state == IDLE && (grant_d || grant_i)) begin
            owner <= grant_d ? OWN_D : OWN_IF;
            we <= grant_d && d_we;
            err <= grant_d && mis;
            be <= grant_d ? d_be : '1;
            addr <= grant_d ? d_addr : if_addr;
            wdata <= grant_d ? d_wdata : '0;
            rdata <= '0;
            // data streak only grows while fetch is actually waiting
            streak <= (grant_d && if_req) ?
                      ((streak == STK_W'(MAX_DATA_STREAK)) ? streak : streak + STK_W'(1)) : '0;
         end
         if (state == WAIT && state_n == RESP) rdata <= mem_rdata;
      end
   end

   assign busy = state != IDLE;
   assign if_ack = state == RESP && owner == OWN_IF;
   assign d_ack = state == RESP && owner == OWN_D;
   assign d_err = d_ack && err;
   assign if_rdata = if_ack ? rdata : '0;
   assign d_rdata = d_ack ? rdata : '0;
   assign mem_en = state == ISSUE;
   assign mem_we = mem_en && we;
   assign mem_be = mem_en ? be : '0;
   assign mem_addr = mem_en ? (addr & ~ADDR_W'(ALIGN_MASK)) : '0;
   assign mem_wdata = mem_en ? wdata : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and randomized checks of the unified memory arbiter
module tb_unified_mem_arbiter;
   localparam int MAXS = 4;
   logic clk = 0, reset = 0;
   logic if_req = 0, d_req = 0, d_we = 0, d_req3 = 0, if_req3 = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0] d_be = 0;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic if_ack, d_ack, d_err, mem_en, mem_we, busy;
   logic if_ack3, d_ack3, d_err3, mem_en3, mem_we3, busy3;
   logic [3:0] mem_be, mem_be3;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS)) u_dut (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_ack(d_ack), .d_err(d_err), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(MAXS)) u_dut3 (
      .clk(clk), .reset(reset), .if_req(if_req3), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ack(if_ack3),
      .d_req(d_req3), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3),
      .d_ack(d_ack3), .d_err(d_err3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

   logic [31:0] mem1 [int unsigned];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] pipe1 = 0, tmp;
   logic [31:0] p3 [3] = '{default: 0};

   function automatic logic [31:0] init_word(input int unsigned w);
      return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] env_rd(input int unsigned w);
      return mem1.exists(w) ? mem1[w] : init_word(w);
   endfunction

   function automatic logic [31:0] ref_rd(input int unsigned w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   // memory macros: read data is only meaningful exactly MEM_LATENCY cycles after mem_en
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         tmp = env_rd(mem_addr >> 2);
         for (int b = 0; b < 4; b++) if (mem_be[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
         mem1[mem_addr >> 2] = tmp;
      end
      pipe1 <= (mem_en && !mem_we) ? env_rd(mem_addr >> 2) : 32'hBAD1_0000;
      p3[0] <= (mem_en3 && !mem_we3) ? env_rd(mem_addr3 >> 2) : 32'hBAD3_0000;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_rdata = pipe1;
   assign mem_rdata3 = p3[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if_req = 0;
      d_req = 0;
      d_req3 = 0;
      reset = 0;
      repeat (2) tick();
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 0;
      if_req = 1;
      d_req = 1;
      d_req3 = 1;
      d_addr = 32'h40;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, if_ack, d_ack, d_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b ack=%b%b en=%b addr=%h want all zero", busy, if_ack, d_ack, mem_en, mem_addr);
         end
         checks++;
         if ({busy3, if_ack3, d_ack3, d_err3, mem_en3, mem_we3, mem_be3, mem_addr3, mem_wdata3, if_rdata3, d_rdata3} !== '0) begin
            failures++;
            $display("FAIL reset_outputs3 got busy=%b ack=%b en=%b want all zero", busy3, d_ack3, mem_en3);
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_fetch();
      do_reset();
      mem1[4] = 32'h0050_0093;
      if_req = 1;
      if_addr = 32'h10;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks += 3;
         if (mem_en !== (c == 1)) begin failures++; $display("FAIL fetch_mem_en c=%0d got=%b want=%b", c, mem_en, c == 1); end
         if (if_ack !== (c == 3)) begin failures++; $display("FAIL fetch_ack c=%0d got=%b want=%b", c, if_ack, c == 3); end
         if (busy !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL fetch_busy c=%0d got=%b", c, busy); end
         if (c == 1) begin
            checks++;
            if ({mem_addr, mem_we, mem_be} !== {32'h10, 1'b0, 4'hF}) begin
               failures++;
               $display("FAIL fetch_issue got addr=%h we=%b be=%h want addr=00000010 we=0 be=f", mem_addr, mem_we, mem_be);
            end
         end
         if (c == 3) begin
            checks++;
            if (if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata got=%h want=00500093", if_rdata); end
         end
         tick();
         if (c == 3) if_req = 0;
      end
   endtask

   task automatic test_store();
      do_reset();
      d_req = 1;
      d_we = 1;
      d_be = 4'hF;
      d_addr = 32'h20;
      d_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks += 3;
         if (mem_en !== (c == 1)) begin failures++; $display("FAIL store_mem_en c=%0d got=%b", c, mem_en); end
         if (mem_we !== (c == 1)) begin failures++; $display("FAIL store_mem_we c=%0d got=%b", c, mem_we); end
         if (d_ack !== (c == 2)) begin failures++; $display("FAIL store_ack c=%0d got=%b want=%b", c, d_ack, c == 2); end
         if (c == 1) begin
            checks++;
            if ({mem_addr, mem_wdata, mem_be} !== {32'h20, 32'hDEAD_BEEF, 4'hF}) begin
               failures++;
               $display("FAIL store_issue got addr=%h wdata=%h be=%h", mem_addr, mem_wdata, mem_be);
            end
         end
         if (c == 2) begin
            checks++;
            if ({d_err, d_rdata} !== 33'd0) begin failures++; $display("FAIL store_resp got err=%b rdata=%h want 0", d_err, d_rdata); end
         end
         tick();
         if (c == 2) d_req = 0;
      end
      checks++;
      if (env_rd(8) !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_mem got=%h want=deadbeef", env_rd(8)); end
   endtask

   task automatic test_misaligned();
      do_reset();
      d_req = 1;
      d_we = 0;
      d_addr = 32'h22;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks += 3;
         if (mem_en !== 1'b0) begin failures++; $display("FAIL mis_mem_en c=%0d got=%b want=0", c, mem_en); end
         if (d_ack !== (c == 1)) begin failures++; $display("FAIL mis_ack c=%0d got=%b want=%b", c, d_ack, c == 1); end
         if (busy !== (c == 1)) begin failures++; $display("FAIL mis_busy c=%0d got=%b", c, busy); end
         if (c == 1) begin
            checks++;
            if ({d_err, d_rdata} !== {1'b1, 32'd0}) begin failures++; $display("FAIL mis_resp got err=%b rdata=%h want err=1 rdata=0", d_err, d_rdata); end
         end
         tick();
         if (c == 1) d_req = 0;
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic prev, seen_d, seen_i, want_d;
      logic [31:0] got_data, want_data;
      do_reset();
      n = 0;
      prev = 0;
      d_we = 0;
      d_addr = 32'h100;
      if_addr = 32'h200;
      if_req = 1;
      d_req = 1;
      for (int c = 0; c < 120 && n < 10; c++) begin
         @(negedge clk);
         seen_d = d_ack;
         seen_i = if_ack;
         if (seen_d || seen_i) begin
            want_d = (n % 5) != 4;
            got_data = seen_d ? d_rdata : if_rdata;
            want_data = init_word(want_d ? (d_addr >> 2) : (if_addr >> 2));
            checks += 3;
            if ({seen_d, seen_i} !== {want_d, !want_d}) begin failures++; $display("FAIL b2b_order n=%0d got d=%b i=%b want d=%b", n, seen_d, seen_i, want_d); end
            if (prev !== 1'b0) begin failures++; $display("FAIL b2b_pulse n=%0d ack held two cycles", n); end
            if (got_data !== want_data) begin failures++; $display("FAIL b2b_data n=%0d got=%h want=%h", n, got_data, want_data); end
            n++;
         end
         prev = seen_d || seen_i;
         tick();
         if (seen_d) d_addr = d_addr + 4;
         if (seen_i) if_addr = if_addr + 4;
      end
      if_req = 0;
      d_req = 0;
      checks++;
      if (n !== 10) begin failures++; $display("FAIL b2b_count got=%0d want=10", n); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      d_req = 1;
      d_we = 0;
      d_addr = 32'h30;
      tick();
      tick();
      #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b want=1", busy); end
      reset = 0;
      #1;
      checks++;
      if ({busy, if_ack, d_ack, d_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
         failures++;
         $display("FAIL midrst_async got busy=%b ack=%b en=%b want all zero", busy, d_ack, mem_en);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (d_ack !== 1'b0) begin failures++; $display("FAIL midrst_no_ack got=%b want=0", d_ack); end
         tick();
      end
      reset = 1;
      d_req = 0;
      @(negedge clk);
      checks++;
      if ({busy, d_ack} !== 2'b00) begin failures++; $display("FAIL midrst_idle got busy=%b ack=%b want 0", busy, d_ack); end
      tick();
      d_req = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (d_ack !== (c == 3)) begin failures++; $display("FAIL midrst_reissue_ack c=%0d got=%b", c, d_ack); end
         if (c == 3) begin
            checks++;
            if (d_rdata !== init_word(12)) begin failures++; $display("FAIL midrst_reissue_data got=%h want=%h", d_rdata, init_word(12)); end
         end
         tick();
         if (c == 3) d_req = 0;
      end
   endtask

   task automatic test_latency3();
      do_reset();
      d_we = 0;
      d_addr = 32'h40;
      d_req3 = 1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks += 3;
         if (mem_en3 !== (c == 1)) begin failures++; $display("FAIL lat3_mem_en c=%0d got=%b", c, mem_en3); end
         if (d_ack3 !== (c == 5)) begin failures++; $display("FAIL lat3_ack c=%0d got=%b want=%b", c, d_ack3, c == 5); end
         if (busy3 !== (c >= 1 && c <= 5)) begin failures++; $display("FAIL lat3_busy c=%0d got=%b", c, busy3); end
         if (c == 5) begin
            checks++;
            if ({d_err3, d_rdata3} !== {1'b0, init_word(16)}) begin failures++; $display("FAIL lat3_data got err=%b rdata=%h want=%h", d_err3, d_rdata3, init_word(16)); end
         end
         tick();
         if (c == 5) d_req3 = 0;
      end
   endtask

   task automatic test_random();
      bit pend, own_d, exp_err, exp_we, ack_i, ack_d;
      int ack_cyc, iss_cyc, streak;
      int unsigned w;
      logic [31:0] exp_data, exp_addr, got;
      do_reset();
      mem1.delete();
      ref_mem.delete();
      pend = 0;
      streak = 0;
      ack_cyc = -1;
      iss_cyc = -1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if (!pend && (if_req || d_req)) begin
            own_d = d_req && (!if_req || streak < MAXS);
            streak = (own_d && if_req) ? ((streak < MAXS) ? streak + 1 : streak) : 0;
            pend = 1;
            if (own_d) begin
               w = d_addr >> 2;
               exp_addr = {d_addr[31:2], 2'b00};
               exp_err = d_addr[1:0] != 2'b00;
               exp_we = d_we;
               exp_data = 0;
               iss_cyc = exp_err ? -1 : cyc + 1;
               ack_cyc = exp_err ? cyc + 1 : (d_we ? cyc + 2 : cyc + 3);
               if (!exp_err && d_we) begin
                  tmp = ref_rd(w);
                  for (int b = 0; b < 4; b++) if (d_be[b]) tmp[8*b +: 8] = d_wdata[8*b +: 8];
                  ref_mem[w] = tmp;
               end else if (!exp_err) exp_data = ref_rd(w);
            end else begin
               exp_addr = {if_addr[31:2], 2'b00};
               exp_err = 0;
               exp_we = 0;
               exp_data = ref_rd(if_addr >> 2);
               iss_cyc = cyc + 1;
               ack_cyc = cyc + 3;
            end
         end
         checks += 2;
         if ({if_ack, d_ack} !== {pend && cyc == ack_cyc && !own_d, pend && cyc == ack_cyc && own_d}) begin
            failures++;
            $display("FAIL rnd_ack cyc=%0d got i=%b d=%b want i=%b d=%b", cyc, if_ack, d_ack, pend && cyc == ack_cyc && !own_d, pend && cyc == ack_cyc && own_d);
         end
         if (mem_en !== (pend && cyc == iss_cyc)) begin failures++; $display("FAIL rnd_mem_en cyc=%0d got=%b", cyc, mem_en); end
         if (pend && cyc == iss_cyc) begin
            checks++;
            if ({mem_addr, mem_we} !== {exp_addr, exp_we}) begin failures++; $display("FAIL rnd_issue cyc=%0d got addr=%h we=%b want addr=%h we=%b", cyc, mem_addr, mem_we, exp_addr, exp_we); end
         end
         if (pend && cyc == ack_cyc) begin
            got = own_d ? d_rdata : if_rdata;
            checks += 2;
            if (got !== exp_data) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, got, exp_data); end
            if (d_err !== (own_d && exp_err)) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, d_err, own_d && exp_err); end
            pend = 0;
         end
         ack_i = if_ack;
         ack_d = d_ack;
         tick();
         if (!if_req || ack_i) begin
            if_req = $urandom_range(0, 2) != 0;
            if_addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         end
         if (!d_req || ack_d) begin
            d_req = $urandom_range(0, 2) != 0;
            d_we = $urandom_range(0, 1) != 0;
            d_be = 4'($urandom_range(0, 15));
            d_wdata = $urandom;
            d_addr = ($urandom_range(0, 15) << 2) | (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
         end
      end
      if_req = 0;
      d_req = 0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_misaligned();
      test_back_to_back();
      test_reset_midflight();
      test_latency3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
